div_man: RTL and testbench

DIV_MAN -- requirements
Module: div_man

---
 rtl/div_pkg.sv | 6 +
 rtl/div_cell.sv | 58 +++++
 rtl/div_man.sv | 63 ++++++
 tb/tb_div_man.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths for the pipelined restoring divider.
// Holds the default dividend/quotient (N) and divisor/remainder (M) widths.
package div_pkg;
  localparam int DIV_N = 8;
  localparam int DIV_M = 4;
endpackage

// File: rtl/div_cell.sv
// One stage of the restoring divider: resolves one quotient bit, MSB first.
// Ports: en in / rdy out; prev_rem, prev_quo, divisor, dividend, zero in;
// registered rem, quo, dvs, dvd (dividend shifted left) and dz out.
module div_cell
  import div_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [M-1:0] prev_rem,
  input  logic [N-1:0] prev_quo,
  input  logic [M-1:0] divisor,
  input  logic [N-1:0] dividend,
  input  logic         zero,
  output logic         rdy,
  output logic [M-1:0] rem,
  output logic [N-1:0] quo,
  output logic [M-1:0] dvs,
  output logic [N-1:0] dvd,
  output logic         dz
);
  logic [M:0] t;
  logic [M:0] diff;
  logic       ge;
  logic       unused_msb;

  // The dividend travels MSB-aligned, so the current bit is always N-1.
  assign t    = {prev_rem, dividend[N-1]};
  assign diff = t - {1'b0, divisor};
  assign ge   = t >= {1'b0, divisor};

  // Quotient shifts in from the LSB; its top bit is still zero here.
  assign unused_msb = prev_quo[N-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      dvd <= '0;
      dz  <= 1'b0;
    end else begin
      rdy <= en;
      if (en) begin
        // Divisor 0 always takes the subtract path; truncation keeps t.
        rem <= ge ? diff[M-1:0] : t[M-1:0];
        quo <= {prev_quo[N-2:0], ge};
        dvs <= divisor;
        dvd <= {dividend[N-2:0], 1'b0};
        dz  <= zero;
      end
    end
  end
endmodule

// File: rtl/div_man.sv
// Fully pipelined unsigned restoring divider, N stages, one op per cycle.
// Ports: data_rdy/dividend/divisor in; res_rdy/quotient/remainder/div_zero out.
module div_man
  import div_pkg::*;
#(
  parameter int N = DIV_N,
  parameter int M = DIV_M
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         res_rdy,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero
);
  logic [M-1:0] rem [N+1];
  logic [N-1:0] quo [N+1];
  logic [M-1:0] dvs [N+1];
  logic [N-1:0] dvd [N+1];
  logic [N:0]   rdy;
  logic [N:0]   dz;
  logic         unused_tail;

  assign rdy[0] = data_rdy;
  assign rem[0] = '0;
  assign quo[0] = '0;
  assign dvs[0] = divisor;
  assign dvd[0] = dividend;
  assign dz[0]  = (divisor == '0);

  for (genvar k = 0; k < N; k++) begin : g_stage
    div_cell #(
      .N(N),
      .M(M)
    ) u_cell (
      .clk     (clk),
      .rstn    (rstn),
      .en      (rdy[k]),
      .prev_rem(rem[k]),
      .prev_quo(quo[k]),
      .divisor (dvs[k]),
      .dividend(dvd[k]),
      .zero    (dz[k]),
      .rdy     (rdy[k+1]),
      .rem     (rem[k+1]),
      .quo     (quo[k+1]),
      .dvs     (dvs[k+1]),
      .dvd     (dvd[k+1]),
      .dz      (dz[k+1])
    );
  end

  // Divisor and shifted dividend are not needed past the last stage.
  assign unused_tail = ^{dvs[N], dvd[N]};

  assign res_rdy   = rdy[N];
  assign quotient  = quo[N];
  assign remainder = rem[N];
  assign div_zero  = dz[N];
endmodule

// File: tb/tb_div_man.sv
// Scoreboard bench for div_man (N=8, M=4): directed vectors plus a
// short randomized run against a division model.
module tb_div_man;
  localparam int N = 8;
  localparam int M = 4;

  logic         clk;
  logic         rstn;
  logic         data_rdy;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         res_rdy;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_zero;

  div_man #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .data_rdy (data_rdy),
    .dividend (dividend),
    .divisor  (divisor),
    .res_rdy  (res_rdy),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  logic [N-1:0] last_q = '0;
  logic [M-1:0] last_r = '0;
  logic         last_z = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Monitor: pops on every result, otherwise checks that outputs hold.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_rdy", int'(res_rdy), 0);
      chk("rst_q", int'(quotient), 0);
      chk("rst_r", int'(remainder), 0);
      chk("rst_z", int'(div_zero), 0);
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end else if (res_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_res: got res_rdy=1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_zero", int'(div_zero), int'(e.z));
        chk("latency", cyc, e.cyc);
        last_q = e.q;
        last_r = e.r;
        last_z = e.z;
      end
    end else begin
      chk("hold_q", int'(quotient), int'(last_q));
      chk("hold_r", int'(remainder), int'(last_r));
      chk("hold_z", int'(div_zero), int'(last_z));
    end
  end

  task automatic issue(input int a, input int d, input int q,
                       input int r, input int z);
    exp_t x;
    data_rdy = 1'b1;
    dividend = N'(a);
    divisor  = M'(d);
    x.q = N'(q);
    x.r = M'(r);
    x.z = z[0];
    x.cyc = cyc + N;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_rdy = 1'b0;
    dividend = 'x;
    divisor  = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_issue(input int a, input int d);
    if (d == 0) issue(a, d, 255, a % 16, 1);
    else issue(a, d, a / d, a % d, 0);
  endtask

  initial begin
    rstn     = 1'b0;
    data_rdy = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    issue(200, 7, 28, 4, 0);
    idle(10);

    issue(255, 15, 17, 0, 0);
    issue(5, 9, 0, 5, 0);
    issue(13, 0, 255, 13, 1);
    idle(10);

    issue(100, 3, 33, 1, 0);
    idle(2);
    issue(64, 8, 8, 0, 0);
    idle(10);

    issue(7, 7, 1, 0, 0);
    issue(0, 5, 0, 0, 0);
    issue(255, 1, 255, 0, 0);
    issue(3, 10, 0, 3, 0);
    issue(0, 0, 255, 0, 1);
    issue(240, 0, 255, 0, 1);
    issue(171, 0, 255, 11, 1);
    issue(199, 13, 15, 4, 0);
    issue(128, 11, 11, 7, 0);
    issue(255, 15, 17, 0, 0);
    idle(10);

    // Reset with three ops in flight: all must be discarded.
    issue(90, 4, 22, 2, 0);
    issue(91, 5, 18, 1, 0);
    issue(92, 6, 15, 2, 0);
    data_rdy = 1'b0;
    rstn = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(16);

    issue(77, 6, 12, 5, 0);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else model_issue(int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 15)));
    end
    idle(N + 4);

    chk("drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
